ot_pack_stream: RTL
===================

Name: ot_pack_stream

Overview:
- Parametrised successor of the output-side byte packer.
- Accepts a configured-length stream of IN_BYTES-wide quantized beats and packs them little-endian into OUT_BYTES-wide words.
- Pushes words into the output stream FIFO with per-byte strobe and a final-word last flag.
- Adds input backpressure, a small output queue, a partial-last-word strobe, and a start/done job handshake. Sits between the quantizer and the AXI4-Stream S2MM interface.

Parameters:
- IN_BYTES, 1, bytes per input beat; must divide OUT_BYTES.
- OUT_BYTES, 8, bytes per output word; fifo_data width is 8*OUT_BYTES.
- LEN_W, 20, width of the job byte-count.
- OQ_DEPTH, 2, output queue depth in words; must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  job start pulse; sampled in IDLE only
- cfg_total_bytes  in  LEN_W  job length in bytes; latched on accepted start; multiple of IN_BYTES
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the job's last word leaves the queue
- valid_in  in  1  input beat valid
- ready_in  out  1  input beat accept
- data_in  in  8*IN_BYTES  input bytes; byte 0 in [7:0]
- fifo_full_n  in  1  downstream FIFO not full
- fifo_write  out  1  push strobe
- fifo_data  out  8*OUT_BYTES  packed word
- fifo_strb  out  OUT_BYTES  valid byte lanes
- fifo_last  out  1  final word of job

Behaviour:
- Reset: state IDLE. busy, done, ready_in, fifo_write, fifo_last = 0; fifo_data = 0; fifo_strb = 0. Accumulator, byte counter and queue are cleared. Reset mid-job abandons the job; no partial word is emitted.
- IDLE:
  - start=1 with cfg_total_bytes != 0: latch the length, clear counters, go to RUN.
  - start with length 0: ignored, stay in IDLE, no done pulse.
- RUN:
  - ready_in = (q_count < OQ_DEPTH). The signal is registered-state only, with no combinational path from fifo_full_n.
  - A beat is accepted when valid_in and ready_in are both high. Its bytes are written to lanes [lane_ptr .. lane_ptr+IN_BYTES-1], where lane_ptr advances by IN_BYTES.
  - When lane_ptr wraps at OUT_BYTES, the word is pushed to the queue with strb all ones and last=0.
  - When the accepted byte count equals the latched length, the word is pushed even if partial. Its strb has the low (filled lanes) bits set, unfilled data lanes are 0, and last=1. The state goes to DRAIN on the same edge.
  - A word completing both conditions at once is pushed once, with full strb and last=1.
- DRAIN: ready_in = 0. When the queue becomes empty, done pulses for 1 cycle and the state returns to IDLE.
- start in RUN or DRAIN is ignored.
- Queue output:
  - fifo_write = (q_count != 0) & fifo_full_n.
  - fifo_data, fifo_strb and fifo_last show the queue head whenever the queue is non-empty, and are 0 when it is empty.
  - The head pops on fifo_write.
  - Push and pop in the same cycle are allowed; q_count is unchanged.
- Latency: the beat completing a word is accepted at edge N; fifo_write is asserted during cycle N+1 if fifo_full_n=1.
- Ordering: words leave in push order. Bytes are never dropped or duplicated under any fifo_full_n pattern.
- Width rules:
  - Byte counter is LEN_W bits and compares by equality.
  - cfg_total_bytes not a multiple of IN_BYTES is illegal (undefined).
  - valid_in while not ready_in holds data_in stable (standard valid/ready).

Test Plan:
- Stream length: IN_BYTES=1, OUT_BYTES=8, length 1920, valid_in every 4th cycle, fifo_full_n=1 -> 240 writes, strb 0xFF on all, fifo_last only on write 240. Data equals golden packing: byte k is in word k/8, lane k%8. done pulses once after write 240.
- Partial last word: length 30 -> 4 writes; words 0-2 have strb 0xFF and last=0. Word 3 has strb 0x3F, last=1, and lanes 6-7 = 0.
- Backpressure: length 64, valid_in held high, fifo_full_n=0 for cycles 5-24 -> queue fills to OQ_DEPTH and ready_in falls. There is no fifo_write while full_n=0. After release, exactly 8 writes occur with no data loss and the golden match holds.
- Zero and repeat start: start with length 0 -> no busy, no done. start during RUN with a different length -> ignored and the original length completes.
- Reset mid-job: assert reset after 13 bytes of a 40-byte job -> all outputs 0 the next cycle with no last. A new 16-byte job then gives 2 correct words, the last with strb 0xFF and last=1.
- Wider input: IN_BYTES=2, OUT_BYTES=8, length 12 -> 2 writes; the second has strb 0x0F and last=1. Byte order is preserved across beat halves.

Source files
------------

// File: rtl/ot_pack_stream.sv
// Packs a configured-length stream of IN_BYTES-wide beats little-endian into OUT_BYTES-wide
// words, queues them and pushes them downstream with byte strobes and a final-word flag.
module ot_pack_stream #(
  parameter int unsigned IN_BYTES  = 1,
  parameter int unsigned OUT_BYTES = 8,
  parameter int unsigned LEN_W     = 20,
  parameter int unsigned OQ_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       cfg_total_bytes,
  output logic                   busy,
  output logic                   done,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [8*IN_BYTES-1:0]  data_in,
  input  logic                   fifo_full_n,
  output logic                   fifo_write,
  output logic [8*OUT_BYTES-1:0] fifo_data,
  output logic [OUT_BYTES-1:0]   fifo_strb,
  output logic                   fifo_last
);

  localparam int unsigned DW     = 8 * OUT_BYTES;
  localparam int unsigned LANE_W = $clog2(OUT_BYTES + 1);
  localparam int unsigned PTR_W  = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;
  localparam int unsigned QCNT_W = $clog2(OQ_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DW-1:0]       acc_q, acc_d;
  logic [DW-1:0]       q_data_q [OQ_DEPTH];
  logic [DW-1:0]       q_data_d [OQ_DEPTH];
  logic [OUT_BYTES-1:0] q_strb_q [OQ_DEPTH];
  logic [OUT_BYTES-1:0] q_strb_d [OQ_DEPTH];
  logic [OQ_DEPTH-1:0] q_last_q, q_last_d;
  logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [QCNT_W-1:0]   q_count_q, q_count_d;

  logic                 accept, push, pop, word_full, word_last;
  logic [LANE_W-1:0]    lane_nxt;
  logic [LEN_W-1:0]     cnt_nxt;
  logic [DW-1:0]        acc_new;
  logic [OUT_BYTES-1:0] strb_new;

  always_comb begin
    ready_in  = (state_q == StRun) && (q_count_q < QCNT_W'(OQ_DEPTH));
    accept    = valid_in && ready_in;
    lane_nxt  = lane_q + LANE_W'(IN_BYTES);
    cnt_nxt   = cnt_q + LEN_W'(IN_BYTES);
    word_full = (lane_nxt == LANE_W'(OUT_BYTES));
    word_last = (cnt_nxt == len_q);
    push      = accept && (word_full || word_last);
    pop       = (q_count_q != '0) && fifo_full_n;
    // Unfilled lanes are already zero because the accumulator is cleared after every push.
    acc_new   = acc_q;
    acc_new[int'(lane_q) * 8 +: 8 * IN_BYTES] = data_in;
    for (int i = 0; i < OUT_BYTES; i++) begin
      strb_new[i] = (i < int'(lane_nxt));
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    q_data_d  = q_data_q;
    q_strb_d  = q_strb_q;
    q_last_d  = q_last_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    q_count_d = q_count_q;

    unique case (state_q)
      StIdle: begin
        if (start && (cfg_total_bytes != '0)) begin
          len_d   = cfg_total_bytes;
          cnt_d   = '0;
          lane_d  = '0;
          acc_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_nxt;
          if (push) begin
            acc_d  = '0;
            lane_d = '0;
          end else begin
            acc_d  = acc_new;
            lane_d = lane_nxt;
          end
          if (word_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (q_count_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (push) begin
      q_data_d[wr_q] = acc_new;
      q_strb_d[wr_q] = strb_new;
      q_last_d[wr_q] = word_last;
      wr_d = (wr_q == PTR_W'(OQ_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = (rd_q == PTR_W'(OQ_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
    end
    if (push && !pop) begin
      q_count_d = q_count_q + QCNT_W'(1);
    end else if (pop && !push) begin
      q_count_d = q_count_q - QCNT_W'(1);
    end
  end

  always_comb begin
    busy       = (state_q != StIdle);
    done       = (state_q == StDrain) && (q_count_q == '0);
    fifo_write = pop;
    fifo_data  = '0;
    fifo_strb  = '0;
    fifo_last  = 1'b0;
    if (q_count_q != '0) begin
      fifo_data = q_data_q[rd_q];
      fifo_strb = q_strb_q[rd_q];
      fifo_last = q_last_q[rd_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      lane_q    <= '0;
      acc_q     <= '0;
      q_last_q  <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      q_count_q <= '0;
      for (int i = 0; i < OQ_DEPTH; i++) begin
        q_data_q[i] <= '0;
        q_strb_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      q_last_q  <= q_last_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      q_count_q <= q_count_d;
      for (int i = 0; i < OQ_DEPTH; i++) begin
        q_data_q[i] <= q_data_d[i];
        q_strb_q[i] <= q_strb_d[i];
      end
    end
  end

endmodule
